// File: rtl/bpu_bht_predictor.sv
// rtl/bpu_bht_predictor.sv - 2-bit counter branch history table with in-flight resolve queue
//
// Predicts the direction of predecoded conditional branches from a PHT of
// 2-bit saturating counters indexed by pc[IDX_W+1:2]. Each predicted branch is
// remembered as {index, prediction} in a small FIFO until the EXU resolves it.
// On resolution the counter that made the prediction is trained.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ifu2bpu_req_i/pc_i         fetch lookup request and fetch PC
//   ifu2bpu_b_type_i/imm_i     conditional-branch flag and signed B-type offset
//   bpu2ifu_rdy_o              in-flight queue has room
//   bpu2ifu_taken_o/target_o   predicted direction and pc + offset
//   exu2bpu_res_vld_i/taken_i  resolution of the oldest branch and its outcome
//   exu2bpu_new_pc_req_i       redirect: discards all in-flight entries
//   bpu2exu_mispred_o          resolved outcome differs from stored prediction
//   bpu_stat_br_o/mis_o        (SCR1_BPU_STATS_EN only) saturating event counters
//
// Optional feature macro: SCR1_BPU_STATS_EN

module bpu_bht_predictor #(
    parameter int BHT_ENTRIES = 16,
    parameter int PC_W        = 32,
    parameter int INFLIGHT    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ifu2bpu_req_i,
    input  logic [PC_W-1:0] ifu2bpu_pc_i,
    input  logic            ifu2bpu_b_type_i,
    input  logic [12:0]     ifu2bpu_imm_i,
    output logic            bpu2ifu_rdy_o,
    output logic            bpu2ifu_taken_o,
    output logic [PC_W-1:0] bpu2ifu_target_o,
    input  logic            exu2bpu_res_vld_i,
    input  logic            exu2bpu_taken_i,
    input  logic            exu2bpu_new_pc_req_i,
    output logic            bpu2exu_mispred_o
`ifdef SCR1_BPU_STATS_EN
    ,
    output logic [31:0]     bpu_stat_br_o,
    output logic [31:0]     bpu_stat_mis_o
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int PTR_W = $clog2(INFLIGHT);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]       pht [BHT_ENTRIES];
    logic [IDX_W-1:0] q_idx [INFLIGHT];
    logic             q_pred [INFLIGHT];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_pred;
    logic             q_full;
    logic             q_empty;
    logic             is_branch;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_idx;
    logic             head_pred;
    logic [1:0]       head_ctr;
    logic [1:0]       trained_ctr;

    assign lookup_idx  = ifu2bpu_pc_i[IDX_W+1:2];
    assign lookup_pred = pht[lookup_idx][1];
    assign q_full      = (count == CNT_W'(INFLIGHT));
    assign q_empty     = (count == '0);

    // rdy is purely occupancy based: a pop in the same cycle does not free a slot early.
    assign bpu2ifu_rdy_o   = ~q_full;
    assign is_branch       = ifu2bpu_req_i & ifu2bpu_b_type_i & ~q_full;
    assign bpu2ifu_taken_o = is_branch & lookup_pred;

    // A redirect in the push cycle squashes the branch being fetched.
    assign push = is_branch & ~exu2bpu_new_pc_req_i;
    assign pop  = exu2bpu_res_vld_i & ~q_empty;

    assign bpu2ifu_target_o = ifu2bpu_pc_i + {{(PC_W-13){ifu2bpu_imm_i[12]}}, ifu2bpu_imm_i};

    assign head_idx          = q_idx[head];
    assign head_pred         = q_pred[head];
    assign head_ctr          = pht[head_idx];
    assign bpu2exu_mispred_o = pop & (exu2bpu_taken_i != head_pred);

    always_comb begin
        trained_ctr = head_ctr;
        if (exu2bpu_taken_i) begin
            if (head_ctr != 2'b11) trained_ctr = head_ctr + 2'b01;
        end else begin
            if (head_ctr != 2'b00) trained_ctr = head_ctr - 2'b01;
        end
    end

    // Counter table: reset to weakly not-taken, trained by the popped head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (pop) begin
            pht[head_idx] <= trained_ctr;
        end
    end

    // Queue payload needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[tail]  <= lookup_idx;
            q_pred[tail] <= lookup_pred;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || exu2bpu_new_pc_req_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

`ifdef SCR1_BPU_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bpu_stat_br_o  <= '0;
            bpu_stat_mis_o <= '0;
        end else begin
            if (pop && bpu_stat_br_o != 32'hFFFF_FFFF)
                bpu_stat_br_o <= bpu_stat_br_o + 32'd1;
            if (bpu2exu_mispred_o && bpu_stat_mis_o != 32'hFFFF_FFFF)
                bpu_stat_mis_o <= bpu_stat_mis_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bpu_bht_predictor.sv
// tb/tb_bpu_bht_predictor.sv - directed self-checking bench for bpu_bht_predictor

module tb_bpu_bht_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] pc;
    logic        b_type;
    logic [12:0] imm;
    logic        rdy;
    logic        taken;
    logic [31:0] target;
    logic        res_vld;
    logic        ex_taken;
    logic        new_pc;
    logic        mispred;
`ifdef SCR1_BPU_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_mis;
`endif

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    bpu_bht_predictor #(.BHT_ENTRIES(16), .PC_W(32), .INFLIGHT(2)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ifu2bpu_req_i        (req),
        .ifu2bpu_pc_i         (pc),
        .ifu2bpu_b_type_i     (b_type),
        .ifu2bpu_imm_i        (imm),
        .bpu2ifu_rdy_o        (rdy),
        .bpu2ifu_taken_o      (taken),
        .bpu2ifu_target_o     (target),
        .exu2bpu_res_vld_i    (res_vld),
        .exu2bpu_taken_i      (ex_taken),
        .exu2bpu_new_pc_req_i (new_pc),
        .bpu2exu_mispred_o    (mispred)
`ifdef SCR1_BPU_STATS_EN
        ,
        .bpu_stat_br_o        (stat_br),
        .bpu_stat_mis_o       (stat_mis)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0; b_type = 1'b0; pc = '0; imm = '0;
        res_vld = 1'b0; ex_taken = 1'b0; new_pc = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] p);
        req = 1'b1; b_type = 1'b1; pc = p; imm = 13'd8;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %0b want 1", rdy); end
        tests_run++; if (taken !== 1'b0) begin fails++; $display("FAIL reset_taken: got %0b want 0", taken); end
        tests_run++; if (mispred !== 1'b0) begin fails++; $display("FAIL reset_mispred: got %0b want 0", mispred); end
    endtask

    task automatic test_lookup();
        lookup(32'h100);
        #1;
        tests_run++; if (taken !== 1'b0) begin fails++; $display("FAIL lookup_taken: got %0b want 0", taken); end
        tests_run++; if (target !== 32'h108) begin fails++; $display("FAIL lookup_target: got %h want 00000108", target); end
        tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL lookup_rdy: got %0b want 1", rdy); end
        tick();
        idle();
        #1;
        tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL lookup_one_entry_rdy: got %0b want 1", rdy); end
    endtask

    // Queue holds one idx0 entry predicted NT; counter idx0 = 01.
    task automatic test_train();
        logic out_t [8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic exp_mis [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic exp_tk [8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            idle();
            res_vld = 1'b1; ex_taken = out_t[i];
            #1;
            tests_run++; if (mispred !== exp_mis[i]) begin fails++; $display("FAIL train_mispred[%0d]: got %0b want %0b", i, mispred, exp_mis[i]); end
            tick();
            idle();
            lookup(32'h100);
            #1;
            tests_run++; if (taken !== exp_tk[i]) begin fails++; $display("FAIL train_taken[%0d]: got %0b want %0b", i, taken, exp_tk[i]); end
            tick();
        end
        idle();
        res_vld = 1'b1; ex_taken = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_full();
        lookup(32'h108); tick();
        idle(); res_vld = 1'b1; ex_taken = 1'b1; tick();
        idle();
        lookup(32'h108);
        #1;
        tests_run++; if (taken !== 1'b1) begin fails++; $display("FAIL full_c1_taken: got %0b want 1", taken); end
        tick();
        tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL full_c2_rdy: got %0b want 1", rdy); end
        tick();
        res_vld = 1'b1; ex_taken = 1'b1;
        #1;
        tests_run++; if (rdy !== 1'b0) begin fails++; $display("FAIL full_rdy: got %0b want 0", rdy); end
        tests_run++; if (taken !== 1'b0) begin fails++; $display("FAIL full_taken: got %0b want 0", taken); end
        tests_run++; if (mispred !== 1'b0) begin fails++; $display("FAIL full_mispred: got %0b want 0", mispred); end
        tick();
        idle();
        #1;
        tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL full_rdy_after_pop: got %0b want 1", rdy); end
        res_vld = 1'b1; ex_taken = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            idle(); res_vld = 1'b1; ex_taken = 1'b0;
            #1;
            tests_run++; if (mispred !== 1'b0) begin fails++; $display("FAIL empty_mispred[%0d]: got %0b want 0", i, mispred); end
            tick();
        end
        idle();
        lookup(32'h108);
        #1;
        tests_run++; if (taken !== 1'b1) begin fails++; $display("FAIL empty_no_train: got %0b want 1", taken); end
        tick();
        idle(); res_vld = 1'b1; ex_taken = 1'b1; tick();
        idle();
    endtask

    task automatic test_flush();
        lookup(32'h104); tick();
        lookup(32'h108); tick();
        idle();
        res_vld = 1'b1; ex_taken = 1'b1; new_pc = 1'b1;
        #1;
        tests_run++; if (mispred !== 1'b1) begin fails++; $display("FAIL flush_mispred: got %0b want 1", mispred); end
        tests_run++; if (rdy !== 1'b0) begin fails++; $display("FAIL flush_rdy_same: got %0b want 0", rdy); end
        tick();
        idle();
        #1;
        tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL flush_rdy_next: got %0b want 1", rdy); end
        res_vld = 1'b1; ex_taken = 1'b0;
        #1;
        tests_run++; if (mispred !== 1'b0) begin fails++; $display("FAIL flush_emptied: got %0b want 0", mispred); end
        tick();
        idle();
        lookup(32'h104);
        #1;
        tests_run++; if (taken !== 1'b1) begin fails++; $display("FAIL flush_head_trained: got %0b want 1", taken); end
        tick();
        new_pc = 1'b1;
        tick();
        idle();
        res_vld = 1'b1; ex_taken = 1'b0;
        #1;
        tests_run++; if (mispred !== 1'b0) begin fails++; $display("FAIL flush_push_dropped: got %0b want 0", mispred); end
        tick();
        idle();
    endtask

    // idx0 = 00, idx1 = 10, queue empty.
    task automatic test_back_to_back();
        lookup(32'h104); tick();
        idle();
        lookup(32'h100);
        res_vld = 1'b1; ex_taken = 1'b1;
        #1;
        tests_run++; if (taken !== 1'b0) begin fails++; $display("FAIL b2b_taken: got %0b want 0", taken); end
        tests_run++; if (mispred !== 1'b0) begin fails++; $display("FAIL b2b_mispred: got %0b want 0", mispred); end
        tick();
        idle();
        #1;
        tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL b2b_occupancy: got %0b want 1", rdy); end
        res_vld = 1'b1; ex_taken = 1'b0;
        #1;
        tests_run++; if (mispred !== 1'b0) begin fails++; $display("FAIL b2b_new_head: got %0b want 0", mispred); end
        tick();
        // idx1 = 11: two pushes, then train down across the prediction boundary.
        idle();
        lookup(32'h104); tick();
        tick();
        idle(); res_vld = 1'b1; ex_taken = 1'b0; tick();
        lookup(32'h104);
        #1;
        tests_run++; if (taken !== 1'b1) begin fails++; $display("FAIL no_bypass_old: got %0b want 1", taken); end
        tests_run++; if (mispred !== 1'b1) begin fails++; $display("FAIL no_bypass_mispred: got %0b want 1", mispred); end
        tick();
        idle();
        lookup(32'h104);
        #1;
        tests_run++; if (taken !== 1'b0) begin fails++; $display("FAIL train_visible_next: got %0b want 0", taken); end
        idle(); res_vld = 1'b1; ex_taken = 1'b0; tick();
        tick();
        idle();
    endtask

    task automatic test_target();
        logic [31:0] pcs  [3] = '{32'hFFFF_FFFC, 32'h0000_0100, 32'h0000_1000};
        logic [12:0] imms [3] = '{13'd8, 13'h1FF8, 13'h1000};
        logic [31:0] exp  [3] = '{32'h0000_0004, 32'h0000_00F8, 32'h0000_0000};
        idle();
        for (int i = 0; i < 3; i++) begin
            pc = pcs[i]; imm = imms[i];
            #1;
            tests_run++; if (target !== exp[i]) begin fails++; $display("FAIL target[%0d]: got %h want %h", i, target, exp[i]); end
        end
        idle();
    endtask

`ifdef SCR1_BPU_STATS_EN
    task automatic test_stats();
        logic outs [3] = '{1'b0, 1'b0, 1'b1};
        idle();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lookup(32'h140); tick();
            idle(); res_vld = 1'b1; ex_taken = outs[i]; tick();
        end
        idle(); res_vld = 1'b1; ex_taken = 1'b1; tick();
        idle();
        tests_run++; if (stat_br !== 32'd3) begin fails++; $display("FAIL stat_br: got %0d want 3", stat_br); end
        tests_run++; if (stat_mis !== 32'd1) begin fails++; $display("FAIL stat_mis: got %0d want 1", stat_mis); end
    endtask
`endif

    initial begin
        test_reset();
        test_lookup();
        test_train();
        test_full();
        test_flush();
        test_back_to_back();
        test_target();
`ifdef SCR1_BPU_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
